// File: rtl/csel_sub_pkg.sv
// Shared types and helpers for the pipelined carry(borrow)-select subtractor.
// Optional saturation is enabled by the CSEL_SUB_SAT_EN macro in the top.
package csel_sub_pkg;

  // Upper bound on operand width; payload fields are sized to it.
  localparam int unsigned MAX_W = 64;

  typedef struct packed {
    logic             valid;
    logic             borrow;
    logic             a_msb;
    logic             b_msb;
    logic [MAX_W-1:0] a_rem;
    logic [MAX_W-1:0] b_rem;
    logic [MAX_W-1:0] diff;
  } stage_t;

  function automatic int unsigned calc_nstg(input int unsigned width, input int unsigned blk);
    return (blk == 0) ? 0 : width / blk;
  endfunction

  // Most-negative value when neg is set, otherwise most-positive, for a width-bit word.
  function automatic logic [MAX_W-1:0] sat_value(input logic neg, input int unsigned width);
    logic [MAX_W-1:0] min_neg;
    min_neg = MAX_W'(1) << (width - 1);
    return neg ? min_neg : min_neg - MAX_W'(1);
  endfunction

endpackage

// File: rtl/csel_sub_block.sv
// One BLK-bit subtract block: both borrow-in candidates are formed, sel_borrow picks one.
module csel_sub_block
  import csel_sub_pkg::*;
#(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a_blk,
  input  logic [BLK-1:0] b_blk,
  input  logic           sel_borrow,
  output logic [BLK-1:0] d_blk,
  output logic           b_out
);

  logic [BLK:0] cand0;
  logic [BLK:0] cand1;

  // The extra top bit is the sign of the widened difference, i.e. the block borrow.
  assign cand0 = {1'b0, a_blk} - {1'b0, b_blk};
  assign cand1 = cand0 - (BLK+1)'(1);

  assign d_blk = sel_borrow ? cand1[BLK-1:0] : cand0[BLK-1:0];
  assign b_out = sel_borrow ? cand1[BLK]     : cand0[BLK];

endmodule

// File: rtl/pipelined_csel_subtractor.sv
// Skewed pipeline computing a - b - borrow_in, one BLK-bit block per stage, valid/ready both sides.
// Define CSEL_SUB_SAT_EN to saturate diff on signed overflow.
module pipelined_csel_subtractor
  import csel_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  localparam int NSTG = int'(calc_nstg(WIDTH, BLK));
  localparam int LAST = NSTG - 1;

  if (BLK < 1 || WIDTH < BLK || (WIDTH % BLK) != 0 || WIDTH > int'(MAX_W)) begin : g_bad_cfg
    $error("pipelined_csel_subtractor: WIDTH must be a multiple of BLK and at most MAX_W");
  end

  stage_t         pipe_q [NSTG];
  stage_t         pipe_d [NSTG];
  stage_t         src    [NSTG];
  logic [BLK-1:0] blk_d  [NSTG];
  logic [NSTG-1:0] blk_b;
  logic [NSTG:0]   adv;

  // Stage 0 is fed straight from the ports; later stages from their predecessor register.
  always_comb begin
    // NOTE: every variable gets a full default first so no path leaves it unassigned (no latch).
    src[0]       = '0;
    src[0].valid = in_valid;
    src[0].borrow = borrow_in;
    src[0].a_msb = a[WIDTH-1];
    src[0].b_msb = b[WIDTH-1];
    src[0].a_rem = MAX_W'(a);
    src[0].b_rem = MAX_W'(b);
    for (int k = 1; k < NSTG; k++) begin
      src[k] = pipe_q[k-1];
    end
  end

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    csel_sub_block #(.BLK(BLK)) u_blk (
      .a_blk      (src[k].a_rem[k*BLK +: BLK]),
      .b_blk      (src[k].b_rem[k*BLK +: BLK]),
      .sel_borrow (src[k].borrow),
      .d_blk      (blk_d[k]),
      .b_out      (blk_b[k])
    );
  end

  always_comb begin
    adv[NSTG] = out_ready;
    for (int k = NSTG - 1; k >= 0; k--) begin
      adv[k] = !pipe_q[k].valid || adv[k+1];
    end
  end

  assign in_ready = adv[0];

  // A stage that may advance takes its predecessor's op, or empties if there is none.
  always_comb begin
    for (int k = 0; k < NSTG; k++) begin
      pipe_d[k] = pipe_q[k];
      if (adv[k]) begin
        pipe_d[k].valid = src[k].valid;
        if (src[k].valid) begin
          pipe_d[k].a_msb = src[k].a_msb;
          pipe_d[k].b_msb = src[k].b_msb;
          pipe_d[k].a_rem = src[k].a_rem;
          pipe_d[k].b_rem = src[k].b_rem;
          pipe_d[k].diff  = src[k].diff;
          pipe_d[k].diff[k*BLK +: BLK] = blk_d[k];
          pipe_d[k].borrow = blk_b[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: payload is cleared along with valid so the outputs read zero after reset.
      for (int k = 0; k < NSTG; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking so every stage samples its predecessor's pre-edge value.
      pipe_q <= pipe_d;
    end
  end

  assign out_valid  = pipe_q[LAST].valid;
  assign borrow_out = pipe_q[LAST].borrow;
  assign ovf        = (pipe_q[LAST].a_msb != pipe_q[LAST].b_msb) &&
                      (pipe_q[LAST].diff[WIDTH-1] != pipe_q[LAST].a_msb);

`ifdef CSEL_SUB_SAT_EN
  assign diff = ovf ? WIDTH'(sat_value(pipe_q[LAST].a_msb, WIDTH))
                    : pipe_q[LAST].diff[WIDTH-1:0];
`else
  assign diff = pipe_q[LAST].diff[WIDTH-1:0];
`endif

endmodule

// File: tb/tb_pipelined_csel_subtractor.sv
// Self-checking bench: directed vector table, stalled/random streams against an arithmetic model,
// mid-flight reset, and a single-stage (WIDTH=8, BLK=8) instance.
module tb_pipelined_csel_subtractor;

`ifdef CSEL_SUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, borrow_in = 1'b0;
  logic        out_valid, out_ready = 1'b0, borrow_out, ovf;
  logic [15:0] a = '0, b = '0, diff;

  logic       in_valid8 = 1'b0, in_ready8, bin8 = 1'b0;
  logic       out_valid8, out_ready8 = 1'b1, bout8, ovf8;
  logic [7:0] a8 = '0, b8 = '0, diff8;

  pipelined_csel_subtractor #(.WIDTH(16), .BLK(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .borrow_in(borrow_in), .out_valid(out_valid), .out_ready(out_ready), .diff(diff),
    .borrow_out(borrow_out), .ovf(ovf)
  );

  pipelined_csel_subtractor #(.WIDTH(8), .BLK(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .borrow_in(bin8), .out_valid(out_valid8), .out_ready(out_ready8), .diff(diff8),
    .borrow_out(bout8), .ovf(ovf8)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  typedef struct packed {
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
  } res_t;

  // Reference: plain integer arithmetic, unsigned for borrow, signed for overflow.
  function automatic res_t model(input logic [15:0] x, input logic [15:0] y, input logic bin);
    int   u, s, sx, sy;
    res_t r;
    u  = int'(x) - int'(y) - int'(bin);
    sx = int'($signed(x));
    sy = int'($signed(y));
    s  = sx - sy - int'(bin);
    r.diff = u[15:0];
    r.bout = (u < 0);
    r.ovf  = (s > 32767) || (s < -32768);
    if (SAT && r.ovf) r.diff = (sx < 0) ? 16'h8000 : 16'h7FFF;
    return r;
  endfunction

  function automatic logic [15:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom());
    endcase
  endfunction

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] e_diff;
    logic        e_bout;
    logic        e_ovf;
  } vec_t;

  vec_t vecs [8];

  // One op through an idle pipe; lat counts cycles from the handshake cycle to out_valid.
  task automatic single(input logic [15:0] x, input logic [15:0] y, input logic bin,
                        output res_t got, output int lat);
    int guard;
    @(negedge clk);
    a = x; b = y; borrow_in = bin; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got.diff = diff;
    got.bout = borrow_out;
    got.ovf  = ovf;
  endtask

  // Stream n ops. Mode 0: out_ready low for the first 7 cycles; mode 1: random valid/ready.
  task automatic run_stream(input int n, input bit random_mode);
    res_t        expq[$];
    res_t        e;
    int          sent = 0, got = 0, cyc = 0;
    bit          held = 1'b0, full_seen = 1'b0, acc, emit;
    logic [17:0] held_val = '0;
    logic [15:0] cur_a, cur_b;
    logic        cur_bin;
    cur_a = rand_operand(); cur_b = rand_operand(); cur_bin = 1'($urandom());
    while ((sent < n || got < n) && cyc < 400) begin
      @(negedge clk);
      if (held) check("hold_stable", {13'd0, out_valid, diff, borrow_out, ovf}, {13'd0, 1'b1, held_val});
      out_ready = random_mode ? ($urandom_range(0, 3) != 0) : (cyc >= 7);
      in_valid  = (sent < n) && (random_mode ? ($urandom_range(0, 3) != 0) : 1'b1);
      a = cur_a; b = cur_b; borrow_in = cur_bin;
      #1;
      if (!random_mode && !full_seen && sent == 4 && !out_ready) begin
        full_seen = 1'b1;
        check("in_ready_full", 32'(in_ready), 32'd0);
        check("out_valid_full", 32'(out_valid), 32'd1);
      end
      acc  = in_valid && in_ready;
      emit = out_valid && out_ready;
      if (emit) begin
        if (expq.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else begin
          e = expq.pop_front();
          check("stream_diff", 32'(diff), 32'(e.diff));
          check("stream_bout", 32'(borrow_out), 32'(e.bout));
          check("stream_ovf", 32'(ovf), 32'(e.ovf));
        end
        got++;
      end
      if (acc) begin
        expq.push_back(model(cur_a, cur_b, cur_bin));
        sent++;
        cur_a = rand_operand(); cur_b = rand_operand(); cur_bin = 1'($urandom());
      end
      held     = out_valid && !out_ready;
      held_val = {diff, borrow_out, ovf};
      cyc++;
    end
    in_valid = 1'b0;
    check("stream_count", 32'(got), 32'(n));
    if (!random_mode) check("stall_seen", 32'(full_seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r;
    int   lat, seen;

    vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, SAT ? 16'h8000 : 16'h7FFF, 1'b0, 1'b1};
    vecs[3] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[4] = '{16'h7FFF, 16'hFFFF, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b1, 1'b1};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h5678, 16'h1234, 1'b1, 16'h4443, 1'b0, 1'b0};
    vecs[7] = '{16'h0F0F, 16'h00F0, 1'b0, 16'h0E1F, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(borrow_out), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid8", 32'(out_valid8), 32'd0);

    // Directed table, one op at a time
    for (int i = 0; i < 8; i++) begin
      single(vecs[i].a, vecs[i].b, vecs[i].bin, r, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      check($sformatf("vec%0d_diff", i), 32'(r.diff), 32'(vecs[i].e_diff));
      check($sformatf("vec%0d_bout", i), 32'(r.bout), 32'(vecs[i].e_bout));
      check($sformatf("vec%0d_ovf", i), 32'(r.ovf), 32'(vecs[i].e_ovf));
    end

    // Back-to-back with a downstream stall, then random valid/ready traffic
    run_stream(8, 1'b0);
    run_stream(60, 1'b1);

    // Reset with three ops in flight
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 16'h9000 + 16'(i); b = 16'h0123; borrow_in = 1'b1; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_diff", 32'(diff), 32'd0);
    check("midrst_bout", 32'(borrow_out), 32'd0);
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no_stale_out", 32'(seen), 32'd0);
    single(16'h4321, 16'h1111, 1'b0, r, lat);
    check("post_rst_diff", 32'(r.diff), 32'h3210);
    check("post_rst_latency", 32'(lat), 32'd4);

    // Single-stage instance
    @(negedge clk);
    a8 = 8'h05; b8 = 8'h07; bin8 = 1'b0; in_valid8 = 1'b1; out_ready8 = 1'b1;
    #1;
    check("w8_in_ready", 32'(in_ready8), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("w8_latency", 32'(lat), 32'd1);
    check("w8_diff", 32'(diff8), 32'h00FE);
    check("w8_bout", 32'(bout8), 32'd1);
    check("w8_ovf", 32'(ovf8), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
